// File: rtl/dual_core_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dual_core_mem_arbiter: round-robin, latency-aware arbiter for the shared   |
// | data port, with per-core pause/resume and stall generation.                |
// | Optional macro ARB_STALL_CNT_EN adds saturating per-core stall counters.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dual_core_mem_arbiter #(
    parameter int AW     = 15,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_0,
    input  logic          req_1,
    input  logic          we_0,
    input  logic          we_1,
    input  logic [AW-1:0] addr_0,
    input  logic [AW-1:0] addr_1,
    input  logic [DW-1:0] wdata_0,
    input  logic [DW-1:0] wdata_1,
    input  logic [2:0]    ctl_0,
    input  logic [2:0]    ctl_1,
    output logic          gnt_0,
    output logic          gnt_1,
    output logic          stall_0,
    output logic          stall_1,
    output logic          rvalid_0,
    output logic          rvalid_1,
    output logic [DW-1:0] rdata,
    output logic [1:0]    run,
`ifdef ARB_STALL_CNT_EN
    output logic [7:0]    stall_cnt_0,
    output logic [7:0]    stall_cnt_1,
`endif
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int              c_CW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(RD_LAT - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_RWAIT = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_rr;
    logic            r_owner;
    logic [1:0]      r_run;
    logic [1:0]      r_rvalid;
    logic [c_CW-1:0] r_cnt;

    logic            w_elig0;
    logic            w_elig1;
    logic            w_any;
    logic            w_win;
    logic            w_wr;
    logic [1:0]      w_gnt;
    logic [1:0]      w_run_nxt;

    // Grants are gated by rst_n so the port stays quiet while reset is held.
    always_comb begin
        w_elig0   = req_0 & r_run[0];
        w_elig1   = req_1 & r_run[1];
        w_any     = rst_n & (r_state == ST_IDLE) & (w_elig0 | w_elig1);
        w_win     = (w_elig0 & w_elig1) ? r_rr : w_elig1;
        w_gnt     = w_any ? (w_win ? 2'b10 : 2'b01) : 2'b00;
        w_wr      = w_win ? we_1 : we_0;
        mem_wen   = w_any & w_wr;
        mem_addr  = w_any ? (w_win ? addr_1 : addr_0) : '0;
        mem_wdata = w_any ? (w_win ? wdata_1 : wdata_0) : '0;
    end

    // ctl_0 is applied last so it overrides ctl_1 on a shared target.
    always_comb begin
        w_run_nxt = r_run;
        if (ctl_1[2]) w_run_nxt[ctl_1[0]] = ctl_1[1];
        if (ctl_0[2]) w_run_nxt[ctl_0[0]] = ctl_0[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_rr     <= 1'b0;
            r_owner  <= 1'b0;
            r_run    <= 2'b11;
            r_rvalid <= 2'b00;
            r_cnt    <= '0;
        end else begin
            r_run <= w_run_nxt;
            if (w_any) r_rr <= ~w_win;
            case (r_state)
                ST_IDLE: begin
                    if (w_any && !w_wr) begin
                        r_state  <= ST_RWAIT;
                        r_owner  <= w_win;
                        r_cnt    <= c_CNT_INIT;
                        r_rvalid <= (RD_LAT == 1) ? (w_win ? 2'b10 : 2'b01) : 2'b00;
                    end
                end
                ST_RWAIT: begin
                    // rvalid is registered one cycle ahead so it lands on T+RD_LAT.
                    if (r_rvalid != 2'b00) begin
                        r_state  <= ST_IDLE;
                        r_rvalid <= 2'b00;
                    end else begin
                        if (r_cnt == c_CNT_ONE) r_rvalid <= r_owner ? 2'b10 : 2'b01;
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt_0    = w_gnt[0];
    assign gnt_1    = w_gnt[1];
    assign rvalid_0 = r_rvalid[0];
    assign rvalid_1 = r_rvalid[1];
    assign rdata    = mem_rdata;
    assign run      = r_run;

    assign stall_0 = (req_0 & ~w_gnt[0]) | ~r_run[0]
                   | ((r_state == ST_RWAIT) & ~r_owner & ~r_rvalid[0]);
    assign stall_1 = (req_1 & ~w_gnt[1]) | ~r_run[1]
                   | ((r_state == ST_RWAIT) & r_owner & ~r_rvalid[1]);

`ifdef ARB_STALL_CNT_EN
    logic [7:0] r_scnt0;
    logic [7:0] r_scnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scnt0 <= 8'd0;
            r_scnt1 <= 8'd0;
        end else begin
            if (w_elig0 && !w_gnt[0] && (r_scnt0 != 8'hFF)) r_scnt0 <= r_scnt0 + 8'd1;
            if (w_elig1 && !w_gnt[1] && (r_scnt1 != 8'hFF)) r_scnt1 <= r_scnt1 + 8'd1;
        end
    end

    assign stall_cnt_0 = r_scnt0;
    assign stall_cnt_1 = r_scnt1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dual_core_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dual_core_mem_arbiter: vectors, corner sequences and a random model     |
// | check for dual_core_mem_arbiter (instances with RD_LAT=1 and RD_LAT=3).    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_dual_core_mem_arbiter;

    localparam logic [15:0] RK = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [14:0] addr [2];
    logic [15:0] wdata [2];
    logic [2:0]  ctl0;
    logic [2:0]  ctl1;

    logic [1:0]  a_gnt, a_stall, a_rv, a_run;
    logic [14:0] a_maddr;
    logic        a_wen;
    logic [15:0] a_wdata, a_rdata, a_mrdata;
    logic [1:0]  b_gnt, b_stall, b_rv, b_run;
    logic [14:0] b_maddr;
    logic        b_wen;
    logic [15:0] b_wdata, b_rdata, b_mrdata;
`ifdef ARB_STALL_CNT_EN
    logic [7:0]  a_sc0, a_sc1, b_sc0, b_sc1;
`endif

    int checks;
    int errors;

    always #5 clk = ~clk;

    dual_core_mem_arbiter #(.AW(15), .DW(16), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_0(req[0]), .req_1(req[1]), .we_0(we[0]), .we_1(we[1]),
        .addr_0(addr[0]), .addr_1(addr[1]), .wdata_0(wdata[0]), .wdata_1(wdata[1]),
        .ctl_0(ctl0), .ctl_1(ctl1),
        .gnt_0(a_gnt[0]), .gnt_1(a_gnt[1]), .stall_0(a_stall[0]), .stall_1(a_stall[1]),
        .rvalid_0(a_rv[0]), .rvalid_1(a_rv[1]), .rdata(a_rdata), .run(a_run),
`ifdef ARB_STALL_CNT_EN
        .stall_cnt_0(a_sc0), .stall_cnt_1(a_sc1),
`endif
        .mem_addr(a_maddr), .mem_wen(a_wen), .mem_wdata(a_wdata), .mem_rdata(a_mrdata)
    );

    dual_core_mem_arbiter #(.AW(15), .DW(16), .RD_LAT(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_0(req[0]), .req_1(req[1]), .we_0(we[0]), .we_1(we[1]),
        .addr_0(addr[0]), .addr_1(addr[1]), .wdata_0(wdata[0]), .wdata_1(wdata[1]),
        .ctl_0(ctl0), .ctl_1(ctl1),
        .gnt_0(b_gnt[0]), .gnt_1(b_gnt[1]), .stall_0(b_stall[0]), .stall_1(b_stall[1]),
        .rvalid_0(b_rv[0]), .rvalid_1(b_rv[1]), .rdata(b_rdata), .run(b_run),
`ifdef ARB_STALL_CNT_EN
        .stall_cnt_0(b_sc0), .stall_cnt_1(b_sc1),
`endif
        .mem_addr(b_maddr), .mem_wen(b_wen), .mem_wdata(b_wdata), .mem_rdata(b_mrdata)
    );

    // Memory models: read data is a fixed function of the address, delayed RD_LAT cycles.
    logic [14:0] a_pipe;
    logic [14:0] b_pipe [3];
    always @(posedge clk) begin
        a_pipe    <= a_maddr;
        b_pipe[0] <= b_maddr;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign a_mrdata = {1'b0, a_pipe} ^ RK;
    assign b_mrdata = {1'b0, b_pipe[2]} ^ RK;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        req = 2'b00; we = 2'b00; ctl0 = 3'b000; ctl1 = 3'b000;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic [1:0] req;
        logic [1:0] we;
        logic [2:0] c0;
        logic [2:0] c1;
        logic [1:0] gnt;
        logic [1:0] stall;
        logic [1:0] rv;
        logic [1:0] run;
        logic       wen;
    } vec_t;

    vec_t tbl [15];

    // Reference model state for the random phase
    int          m_left;
    logic        m_rr, m_owner;
    logic [1:0]  m_run;
    logic [14:0] m_raddr;

    initial begin
        logic        seen;
        logic        has, w;
        logic [1:0]  e_gnt, e_stall, e_rv;
        logic        e_wen;

        checks = 0;
        errors = 0;

        // idle, core0 read, rvalid, idle, core1 write, 4 contended writes,
        // conflicting pause cmds, ignored core1 requests, resume, grant
        tbl[0]  = '{2'b00, 2'b00, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0};
        tbl[1]  = '{2'b01, 2'b00, 3'b000, 3'b000, 2'b01, 2'b00, 2'b00, 2'b11, 1'b0};
        tbl[2]  = '{2'b00, 2'b00, 3'b000, 3'b000, 2'b00, 2'b00, 2'b01, 2'b11, 1'b0};
        tbl[3]  = '{2'b00, 2'b00, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0};
        tbl[4]  = '{2'b10, 2'b10, 3'b000, 3'b000, 2'b10, 2'b00, 2'b00, 2'b11, 1'b1};
        tbl[5]  = '{2'b11, 2'b11, 3'b000, 3'b000, 2'b01, 2'b10, 2'b00, 2'b11, 1'b1};
        tbl[6]  = '{2'b11, 2'b11, 3'b000, 3'b000, 2'b10, 2'b01, 2'b00, 2'b11, 1'b1};
        tbl[7]  = '{2'b11, 2'b11, 3'b000, 3'b000, 2'b01, 2'b10, 2'b00, 2'b11, 1'b1};
        tbl[8]  = '{2'b11, 2'b11, 3'b000, 3'b000, 2'b10, 2'b01, 2'b00, 2'b11, 1'b1};
        tbl[9]  = '{2'b00, 2'b00, 3'b101, 3'b111, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0};
        tbl[10] = '{2'b10, 2'b10, 3'b000, 3'b000, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
        tbl[11] = '{2'b10, 2'b10, 3'b000, 3'b000, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
        tbl[12] = '{2'b10, 2'b10, 3'b111, 3'b000, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
        tbl[13] = '{2'b10, 2'b10, 3'b000, 3'b000, 2'b10, 2'b00, 2'b00, 2'b11, 1'b1};
        tbl[14] = '{2'b00, 2'b00, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0};

        // Reset state with requests asserted: nothing may be granted
        clear_in();
        rst_n = 1'b0;
        req = 2'b11; we = 2'b11; addr[0] = 15'h1234; wdata[0] = 16'hBEEF;
        @(negedge clk);
        check("reset_ctl", {a_gnt, a_wen, a_rv, a_run}, {2'b00, 1'b0, 2'b00, 2'b11});
        check("reset_bus", {a_maddr, a_wdata}, 31'd0);
        do_reset();

        // Table-driven sequence on the RD_LAT=1 instance
        addr[0] = 15'h0010; addr[1] = 15'h0020; wdata[0] = 16'h1111; wdata[1] = 16'h2222;
        for (int i = 0; i < 15; i++) begin
            req = tbl[i].req; we = tbl[i].we; ctl0 = tbl[i].c0; ctl1 = tbl[i].c1;
            @(negedge clk);
            check($sformatf("vec%0d", i), {a_gnt, a_stall, a_rv, a_run, a_wen},
                  {tbl[i].gnt, tbl[i].stall, tbl[i].rv, tbl[i].run, tbl[i].wen});
            if (tbl[i].rv != 2'b00) check("vec_rdata", a_rdata, {1'b0, 15'h0010} ^ RK);
            tick();
        end

        // RD_LAT=3: core 1 read blocks core 0 writes for three cycles
        do_reset();
        req = 2'b11; we = 2'b01; addr[0] = 15'h0005; addr[1] = 15'h0123;
        @(negedge clk);
        check("s3_first_gnt", b_gnt, 2'b01);
        tick();
        @(negedge clk);
        check("s3_read_gnt", {b_gnt, b_wen}, {2'b10, 1'b0});
        tick();
        req = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("s3_T+%0d", k), {b_gnt, b_rv, b_stall[1]},
                  {(k == 4) ? 2'b01 : 2'b00, (k == 3) ? 2'b10 : 2'b00, (k < 3) ? 1'b1 : 1'b0});
            if (k == 3) check("s3_rdata", b_rdata, {1'b0, 15'h0123} ^ RK);
            tick();
        end

        // Reset pulse during an outstanding read
        do_reset();
        seen = 1'b0;
        req = 2'b10; we = 2'b00; addr[1] = 15'h0456;
        @(negedge clk);
        check("s5_gnt", b_gnt, 2'b10);
        tick();
        req = 2'b00; ctl0 = 3'b100;
        @(negedge clk);
        seen |= b_rv[1];
        tick();
        ctl0 = 3'b000;
        @(negedge clk);
        seen |= b_rv[1];
        #1 rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen |= b_rv[1];
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            seen |= b_rv[1];
            tick();
        end
        check("s5_no_rvalid", seen, 1'b0);
        req = 2'b11; we = 2'b11;
        @(negedge clk);
        check("s5_after_reset", {b_run, b_gnt}, {2'b11, 2'b01});
        tick();

        // Random stimulus against the reference model (RD_LAT=1 instance)
        do_reset();
        m_left = 0; m_rr = 1'b0; m_owner = 1'b0; m_run = 2'b11; m_raddr = '0;
        for (int c = 0; c < 400; c++) begin
            req      = 2'($urandom_range(0, 3));
            we       = 2'($urandom_range(0, 3));
            addr[0]  = 15'($urandom);
            addr[1]  = 15'($urandom);
            wdata[0] = 16'($urandom);
            wdata[1] = 16'($urandom);
            ctl0     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'b000;
            ctl1     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'b000;
            if (c % 40 == 39) begin ctl0 = 3'b111; ctl1 = 3'b110; end

            has     = (m_left == 0) && ((req[0] && m_run[0]) || (req[1] && m_run[1]));
            w       = (req[0] && m_run[0] && req[1] && m_run[1]) ? m_rr : (req[1] && m_run[1]);
            e_gnt   = has ? (w ? 2'b10 : 2'b01) : 2'b00;
            e_wen   = has && we[w];
            e_rv    = (m_left == 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            for (int x = 0; x < 2; x++)
                e_stall[x] = (req[x] && !e_gnt[x]) || !m_run[x] || (m_left > 1 && m_owner == 1'(x));

            @(negedge clk);
            check($sformatf("rnd%0d_ctl", c), {a_gnt, a_stall, a_rv, a_wen, a_run},
                  {e_gnt, e_stall, e_rv, e_wen, m_run});
            if (has) check($sformatf("rnd%0d_bus", c), {a_maddr, a_wdata}, {addr[w], wdata[w]});
            if (e_rv != 2'b00) check($sformatf("rnd%0d_rdata", c), a_rdata, {1'b0, m_raddr} ^ RK);

            if (m_left > 0) m_left--;
            if (has) begin
                m_rr = !w;
                if (!we[w]) begin
                    m_left  = 1;
                    m_owner = w;
                    m_raddr = addr[w];
                end
            end
            if (ctl1[2]) m_run[ctl1[0]] = ctl1[1];
            if (ctl0[2]) m_run[ctl0[0]] = ctl0[1];
            tick();
        end

`ifdef ARB_STALL_CNT_EN
        // Contended writes: each core loses every other cycle until saturation
        do_reset();
        @(negedge clk);
        check("scnt_reset", {a_sc0, a_sc1}, 16'h0000);
        req = 2'b11; we = 2'b11;
        repeat (20) tick();
        @(negedge clk);
        check("scnt_20", {a_sc0, a_sc1}, {8'd10, 8'd10});
        repeat (580) tick();
        @(negedge clk);
        check("scnt_sat", {a_sc0, a_sc1}, {8'd255, 8'd255});
        tick();
        clear_in();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
